sisc_fetch_unit: RTL and testbench

Parametrised instruction fetch unit for the SISC processor. It replaces the directly driven 32-bit `ir` input of the part-1 datapath with a program counter, an instruction memory request/wait sequencer and a registered instruction register. It offers each instruction to the control unit through a valid/ready handshake. It redirects the program counter on branches, stops fetching on HALT, and tolerates instruction memories with configurable read latency.

---
 rtl/sisc_fetch_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_sisc_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_fetch_unit.sv
// ---------------------------------------------------------------------------
// sisc_fetch_unit
//
// Instruction fetch unit for the SISC processor.
// It holds the program counter and issues one read per instruction to the
// instruction memory. It waits out the memory's read latency and then
// captures the returned word into a registered instruction register. The
// control unit takes that word through a valid/ready handshake. A handshake
// with a taken branch redirects the PC. A consumed HALT instruction stops
// fetching until reset.
//
// Parameters:
//   INSTR_W  instruction width; opcode is ir[INSTR_W-1 -: 4]
//   PC_W     program counter / instruction address width
//   MEM_LAT  instruction-memory read latency in cycles (1..4)
//   HALT_OP  opcode value that halts fetching
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active high
//   im_rd      out  read strobe, one cycle per fetch (registered)
//   im_addr    out  read address, direct copy of pc
//   im_data    in   read data, valid MEM_LAT cycles after the im_rd cycle
//   ir         out  registered instruction
//   ir_valid   out  ir holds an unconsumed instruction
//   ir_ready   in   control unit accepts ir this cycle
//   br_taken   in   redirect PC (sampled only on a handshake cycle)
//   br_abs     in   1 = absolute target, 0 = PC-relative offset
//   br_target  in   absolute address or two's-complement offset
//   pc         out  address of the next instruction to fetch
//   halted     out  HALT consumed, fetching stopped
//
// Build option:
//   SISC_FETCH_REL_BR_EN  defined: br_abs=0 selects a PC-relative branch.
//                         undefined: every taken branch is absolute and
//                         br_abs is ignored.
// ---------------------------------------------------------------------------
module sisc_fetch_unit #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned MEM_LAT = 1,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               im_rd,
  output logic [PC_W-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_taken,
  input  logic               br_abs,
  input  logic [PC_W-1:0]    br_target,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  // A 2-bit counter covers latencies 1..4 (load value 0..3).
  localparam int unsigned    CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    pc_nxt_s;
  logic [INSTR_W-1:0] ir_r;
  logic [INSTR_W-1:0] ir_nxt_s;
  logic               ir_valid_r;
  logic               ir_valid_nxt_s;
  logic               im_rd_r;
  logic               im_rd_nxt_s;
  logic               halted_r;
  logic               halted_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;

  logic [3:0]         opcode_s;
  logic               is_halt_s;
  logic [PC_W-1:0]    br_dest_s;

  assign opcode_s  = ir_r[INSTR_W-1 -: 4];
  assign is_halt_s = (opcode_s == HALT_OP);

`ifdef SISC_FETCH_REL_BR_EN
  // Branch destination: absolute target, or offset added to the already-incremented pc.
  always_comb begin
    br_dest_s = br_target;
    if (br_abs) begin
      br_dest_s = br_target;
    end else begin
      br_dest_s = pc_r + br_target;
    end
  end
`else
  // Every taken branch is absolute in this build, so br_abs has no effect.
  logic unused_br_abs_s;
  assign unused_br_abs_s = br_abs;
  assign br_dest_s       = br_target;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ISSUE: begin
        if (ir_ready) begin
          if (is_halt_s) begin
            state_nxt_s = ST_HALTED;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output/datapath logic: next values of the registered outputs and the latency counter.
  always_comb begin
    pc_nxt_s       = pc_r;
    ir_nxt_s       = ir_r;
    ir_valid_nxt_s = ir_valid_r;
    cnt_nxt_s      = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
      end
      ST_REQ: begin
        cnt_nxt_s = CNT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          ir_nxt_s       = im_data;
          ir_valid_nxt_s = 1'b1;
          pc_nxt_s       = pc_r + PC_ONE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_ISSUE: begin
        if (ir_ready) begin
          ir_valid_nxt_s = 1'b0;
          // A HALT never redirects, so pc keeps pointing past it.
          if (br_taken && !is_halt_s) begin
            pc_nxt_s = br_dest_s;
          end else begin
            pc_nxt_s = pc_r;
          end
        end else begin
          ir_valid_nxt_s = ir_valid_r;
        end
      end
      ST_HALTED: begin
        ir_valid_nxt_s = 1'b0;
      end
      default: begin
        pc_nxt_s       = PC_ZERO;
        ir_nxt_s       = {INSTR_W{1'b0}};
        ir_valid_nxt_s = 1'b0;
        cnt_nxt_s      = CNT_ZERO;
      end
    endcase
    // Strobe and halted flag are registered copies of the upcoming state.
    im_rd_nxt_s  = (state_nxt_s == ST_REQ);
    halted_nxt_s = (state_nxt_s == ST_HALTED);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= PC_ZERO;
      ir_r       <= {INSTR_W{1'b0}};
      ir_valid_r <= 1'b0;
      im_rd_r    <= 1'b0;
      halted_r   <= 1'b0;
      cnt_r      <= CNT_ZERO;
    end else begin
      pc_r       <= pc_nxt_s;
      ir_r       <= ir_nxt_s;
      ir_valid_r <= ir_valid_nxt_s;
      im_rd_r    <= im_rd_nxt_s;
      halted_r   <= halted_nxt_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

  assign pc       = pc_r;
  assign im_addr  = pc_r;
  assign ir       = ir_r;
  assign ir_valid = ir_valid_r;
  assign im_rd    = im_rd_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_sisc_fetch_unit
//
// Directed bench for sisc_fetch_unit. Instance a uses MEM_LAT=1 and instance
// b uses MEM_LAT=3. Each instance has its own behavioural instruction memory.
// Memory words default to {4'h1, 12'h000, address}, so ir shows which
// address was fetched. Outputs are sampled on the falling clock edge, and
// inputs are also changed there.
// ---------------------------------------------------------------------------
module tb_sisc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:65535];

  // ---------------- instance a: MEM_LAT = 1 ----------------
  logic        a_rst, a_im_rd, a_ir_valid, a_ir_ready, a_br_taken, a_br_abs, a_halted;
  logic [15:0] a_im_addr, a_br_target, a_pc;
  logic [31:0] a_im_data, a_ir, a_pipe;

  sisc_fetch_unit #(.INSTR_W(32), .PC_W(16), .MEM_LAT(1), .HALT_OP(4'hF)) dut_a (
    .clk(clk), .rst(a_rst), .im_rd(a_im_rd), .im_addr(a_im_addr), .im_data(a_im_data),
    .ir(a_ir), .ir_valid(a_ir_valid), .ir_ready(a_ir_ready), .br_taken(a_br_taken),
    .br_abs(a_br_abs), .br_target(a_br_target), .pc(a_pc), .halted(a_halted)
  );

  always_ff @(posedge clk) a_pipe <= a_im_rd ? mem[a_im_addr] : 32'hDEADBEEF;
  assign a_im_data = a_pipe;

  // ---------------- instance b: MEM_LAT = 3 ----------------
  logic        b_rst, b_im_rd, b_ir_valid, b_ir_ready, b_halted;
  logic        b_br_taken = 1'b0;
  logic        b_br_abs   = 1'b1;
  logic [15:0] b_br_target = 16'h0000;
  logic [15:0] b_im_addr, b_pc;
  logic [31:0] b_im_data, b_ir;
  logic [31:0] b_pipe [0:2];

  sisc_fetch_unit #(.INSTR_W(32), .PC_W(16), .MEM_LAT(3), .HALT_OP(4'hF)) dut_b (
    .clk(clk), .rst(b_rst), .im_rd(b_im_rd), .im_addr(b_im_addr), .im_data(b_im_data),
    .ir(b_ir), .ir_valid(b_ir_valid), .ir_ready(b_ir_ready), .br_taken(b_br_taken),
    .br_abs(b_br_abs), .br_target(b_br_target), .pc(b_pc), .halted(b_halted)
  );

  always_ff @(posedge clk) begin
    b_pipe[0] <= b_im_rd ? mem[b_im_addr] : 32'hDEADBEEF;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_im_data = b_pipe[2];

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {4'h1, 12'h000, a};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_ir_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_ir_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Handshake on instance a, optionally with a branch, leaving the next state visible.
  task automatic handshake_a(input logic tk, input logic ab, input logic [15:0] tgt);
    a_ir_ready = 1'b1; a_br_taken = tk; a_br_abs = ab; a_br_target = tgt;
    tick();
    a_ir_ready = 1'b0; a_br_taken = 1'b0; a_br_abs = 1'b1; a_br_target = 16'h0000;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    tick(); tick();
    tests_run++;
    if ({a_im_rd, a_ir_valid, a_halted, a_pc, a_ir} !== {1'b0, 1'b0, 1'b0, 16'h0000, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: rd/valid/halted/pc/ir = %b/%b/%b/%h/%h required 0/0/0/0000/00000000",
               a_im_rd, a_ir_valid, a_halted, a_pc, a_ir);
    end
    a_rst = 1'b0;
    tick();  // edge 1
    tests_run++;
    if (a_im_rd !== 1'b1 || a_im_addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL first_req: im_rd=%b im_addr=%h required 1 0000", a_im_rd, a_im_addr);
    end
    tick();  // edge 2
    tests_run++;
    if (a_im_rd !== 1'b0 || a_ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_cycle: im_rd=%b ir_valid=%b required 0 0", a_im_rd, a_ir_valid);
    end
    tick();  // edge 3
    tests_run++;
    if (a_ir_valid !== 1'b1 || a_ir !== 32'h21100001 || a_pc !== 16'h0001) begin
      tests_failed++;
      $display("FAIL first_issue: valid=%b ir=%h pc=%h required 1 21100001 0001",
               a_ir_valid, a_ir, a_pc);
    end
  endtask

  task automatic test_backpressure();
    bit stable = 1'b1;
    bit ok;
    // A branch request outside a handshake must be ignored.
    a_ir_ready = 1'b0; a_br_taken = 1'b1; a_br_abs = 1'b1; a_br_target = 16'h0055;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_ir !== 32'h21100001 || a_ir_valid !== 1'b1 || a_pc !== 16'h0001 || a_im_rd !== 1'b0)
        stable = 1'b0;
    end
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_hold: ir=%h valid=%b pc=%h rd=%b required stable 21100001 1 0001 0",
               a_ir, a_ir_valid, a_pc, a_im_rd);
    end
    handshake_a(1'b0, 1'b1, 16'h0000);
    tests_run++;
    if (a_im_rd !== 1'b1 || a_im_addr !== 16'h0001 || a_ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_req: rd=%b addr=%h valid=%b required 1 0001 0", a_im_rd, a_im_addr, a_ir_valid);
    end
    wait_valid_a(ok);
    tests_run++;
    if (!ok || a_ir !== dflt(16'h0001) || a_pc !== 16'h0002) begin
      tests_failed++;
      $display("FAIL second_fetch: ir=%h pc=%h required %h 0002", a_ir, a_pc, dflt(16'h0001));
    end
  endtask

  task automatic test_abs_branch();
    bit ok;
    handshake_a(1'b1, 1'b1, 16'h0040);
    tests_run++;
    if (a_im_rd !== 1'b1 || a_im_addr !== 16'h0040) begin
      tests_failed++;
      $display("FAIL abs_branch_req: rd=%b addr=%h required 1 0040", a_im_rd, a_im_addr);
    end
    wait_valid_a(ok);
    tests_run++;
    if (!ok || a_ir !== dflt(16'h0040) || a_pc !== 16'h0041) begin
      tests_failed++;
      $display("FAIL abs_branch_fetch: ir=%h pc=%h required %h 0041", a_ir, a_pc, dflt(16'h0040));
    end
  endtask

  task automatic test_rel_branch();
    bit ok;
    logic [15:0] exp_addr;
`ifdef SISC_FETCH_REL_BR_EN
    exp_addr = 16'h000F;
`else
    exp_addr = 16'hFFFE;
`endif
    handshake_a(1'b1, 1'b1, 16'h0010);
    wait_valid_a(ok);
    tests_run++;
    if (!ok || a_pc !== 16'h0011) begin
      tests_failed++;
      $display("FAIL rel_setup: pc=%h required 0011", a_pc);
    end
    handshake_a(1'b1, 1'b0, 16'hFFFE);
    tests_run++;
    if (a_im_rd !== 1'b1 || a_im_addr !== exp_addr) begin
      tests_failed++;
      $display("FAIL rel_branch_req: rd=%b addr=%h required 1 %h", a_im_rd, a_im_addr, exp_addr);
    end
    wait_valid_a(ok);
    tests_run++;
    if (!ok || a_ir !== dflt(exp_addr)) begin
      tests_failed++;
      $display("FAIL rel_branch_fetch: ir=%h required %h", a_ir, dflt(exp_addr));
    end
  endtask

  task automatic test_wrap();
    bit ok;
    handshake_a(1'b1, 1'b1, 16'hFFFF);
    wait_valid_a(ok);
    tests_run++;
    if (!ok || a_ir !== dflt(16'hFFFF) || a_pc !== 16'h0000) begin
      tests_failed++;
      $display("FAIL pc_wrap: ir=%h pc=%h required %h 0000", a_ir, a_pc, dflt(16'hFFFF));
    end
  endtask

  task automatic test_halt();
    bit ok;
    bit quiet = 1'b1;
    handshake_a(1'b1, 1'b1, 16'h0100);
    wait_valid_a(ok);
    tests_run++;
    if (!ok || a_ir !== 32'hF0000000 || a_pc !== 16'h0101) begin
      tests_failed++;
      $display("FAIL halt_fetch: ir=%h pc=%h required F0000000 0101", a_ir, a_pc);
    end
    handshake_a(1'b1, 1'b1, 16'h0200);
    tests_run++;
    if (a_halted !== 1'b1 || a_pc !== 16'h0101 || a_ir_valid !== 1'b0 || a_ir !== 32'hF0000000) begin
      tests_failed++;
      $display("FAIL halt_enter: halted=%b pc=%h valid=%b ir=%h required 1 0101 0 F0000000",
               a_halted, a_pc, a_ir_valid, a_ir);
    end
    a_ir_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_im_rd !== 1'b0 || a_halted !== 1'b1 || a_pc !== 16'h0101) quiet = 1'b0;
    end
    a_ir_ready = 1'b0;
    tests_run++;
    if (quiet !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_stays: rd=%b halted=%b pc=%h required 0 1 0101 for 20 cycles",
               a_im_rd, a_halted, a_pc);
    end
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    tests_run++;
    if (a_halted !== 1'b0 || a_pc !== 16'h0000 || a_ir !== 32'h0) begin
      tests_failed++;
      $display("FAIL halt_reset: halted=%b pc=%h ir=%h required 0 0000 00000000", a_halted, a_pc, a_ir);
    end
    tick();
    tests_run++;
    if (a_im_rd !== 1'b1 || a_im_addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL halt_restart: rd=%b addr=%h required 1 0000", a_im_rd, a_im_addr);
    end
  endtask

  task automatic test_back_to_back_a();
    bit ok;
    int gap = 0;
    a_ir_ready = 1'b1;
    wait_valid_a(ok);
    for (int i = 0; i < 20; i++) begin
      tick();
      gap++;
      if (a_ir_valid) break;
    end
    a_ir_ready = 1'b0;
    tests_run++;
    if (!ok || gap != 3) begin
      tests_failed++;
      $display("FAIL b2b_lat1: issue period=%0d required 3", gap);
    end
  endtask

  task automatic test_midop_reset();
    bit ok;
    int gap = 0;
    b_ir_ready = 1'b0;
    b_rst = 1'b0;
    tick(); tick(); tick();  // edges 1..3: REQ, WAIT, WAIT
    b_rst = 1'b1;
    tick();                  // edge 4: reset while in WAIT
    b_rst = 1'b0;
    tests_run++;
    if (b_ir !== 32'h0 || b_ir_valid !== 1'b0 || b_pc !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midop_reset: ir=%h valid=%b pc=%h required 00000000 0 0000", b_ir, b_ir_valid, b_pc);
    end
    tick();                  // edge 5: late data present, must not be captured
    tests_run++;
    if (b_ir !== 32'h0 || b_ir_valid !== 1'b0 || b_im_rd !== 1'b1 || b_im_addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL late_data: ir=%h valid=%b rd=%b addr=%h required 00000000 0 1 0000",
               b_ir, b_ir_valid, b_im_rd, b_im_addr);
    end
    wait_valid_b(ok);
    tests_run++;
    if (!ok || b_ir !== 32'h21100001 || b_pc !== 16'h0001) begin
      tests_failed++;
      $display("FAIL lat3_fetch: ir=%h pc=%h required 21100001 0001", b_ir, b_pc);
    end
    b_ir_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      gap++;
      if (b_ir_valid) break;
    end
    b_ir_ready = 1'b0;
    tests_run++;
    if (gap != 5 || b_ir !== dflt(16'h0001)) begin
      tests_failed++;
      $display("FAIL b2b_lat3: period=%0d ir=%h required 5 %h", gap, b_ir, dflt(16'h0001));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = dflt(16'(i));
    mem[0]        = 32'h21100001;
    mem[16'h0100] = 32'hF0000000;
    a_rst = 1'b1; b_rst = 1'b1;
    a_ir_ready = 1'b0; a_br_taken = 1'b0; a_br_abs = 1'b1; a_br_target = 16'h0000;
    b_ir_ready = 1'b0;
    test_reset();
    test_backpressure();
    test_abs_branch();
    test_rel_branch();
    test_wrap();
    test_halt();
    test_back_to_back_a();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
